// File: rtl/inst_load_pkg.sv
`default_nettype none
// ============================================================================
// Module      : inst_load_pkg
// Description : Shared types and constants for the instruction-memory boot
//               loader. These are the loader FSM state encoding, the default
//               RAM depth and the frame geometry.
// Revision    : 1.0 - initial release
// ============================================================================
package inst_load_pkg;

    // log2 of instruction RAM depth in words
    localparam int DEPTH_LOG2_DEFAULT = 6;

    // Frame geometry: two length bytes, then four bytes per instruction word
    localparam int HDR_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;

    // Loader state encoding
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_HI = 3'd1,
        LEN_LO = 3'd2,
        DATA   = 3'd3,
        CSUM   = 3'd4,
        DONE   = 3'd5,
        ERROR  = 3'd6
    } state_t;

endpackage : inst_load_pkg
`default_nettype wire

// File: rtl/inst_mem_loader_byte_packer.sv
`default_nettype none
// ============================================================================
// Module      : byte_packer
// Description : Assembles big-endian 32-bit words from a byte stream. The
//               first byte received becomes the MSB. o_word_valid is asserted
//               combinationally in the cycle the 4th byte arrives, with
//               o_word carrying the complete word in that cycle.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               i_clear         - synchronous restart at byte 0
//               i_valid/i_byte  - incoming byte strobe and data
//               o_word          - assembled word (valid with o_word_valid)
//               o_word_valid    - 4th byte of a word is present this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module byte_packer
    import inst_load_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clear,
    input  logic        i_valid,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_word_valid
);

    localparam int c_shift_w = 8 * (BYTES_PER_WORD - 1);

    logic [1:0]           r_cnt;
    logic [c_shift_w-1:0] r_shift;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_cnt   <= 2'd0;
            r_shift <= '0;
        end else if (i_valid) begin
            // Counter wraps 3 -> 0 so the next word starts cleanly
            r_cnt   <= r_cnt + 2'd1;
            r_shift <= {r_shift[c_shift_w-9:0], i_byte};
        end
    end

    assign o_word_valid = i_valid && (r_cnt == 2'd3);
    assign o_word       = {r_shift, i_byte};

endmodule : byte_packer
`default_nettype wire

// File: rtl/inst_mem_loader.sv
`default_nettype none
// ============================================================================
// Module      : inst_mem_loader
// Description : Boot-time loader for the instruction RAM. It parses a framed
//               byte stream from the UART receiver, writes big-endian words
//               into the RAM write port and holds the CPU in reset until a
//               checksum-verified image is complete.
//               Frame layout: LEN_HI LEN_LO, 4*N data bytes, CSUM. The XOR
//               of all frame bytes must be 0x00.
// Ports       : clk, rst           - clock, synchronous active-high reset
//               start              - pulse, begin a new load (only when idle/
//                                    finished)
//               rx_data, rx_valid  - byte stream, no backpressure
//               we, wa, wd         - instruction RAM write port (registered)
//               hold               - CPU reset request
//               done, err          - outcome of the last load (levels)
// Revision    : 1.0 - initial release
// ============================================================================
module inst_mem_loader
    import inst_load_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  we,
    output logic [DEPTH_LOG2-1:0] wa,
    output logic [31:0]           wd,
    output logic                  hold,
    output logic                  done,
    output logic                  err
);

    // Largest legal word count (a full RAM). 17 bits so 2^16 also fits.
    localparam logic [16:0] c_max_words = 17'(1) << DEPTH_LOG2;

    state_t                r_state;
    logic [7:0]            r_len_hi;
    logic [7:0]            r_xor;
    logic [DEPTH_LOG2-1:0] r_word_cnt;
    logic [DEPTH_LOG2-1:0] r_last;

    logic                  w_start_ok;
    logic                  w_pk_valid;
    logic                  w_word_valid;
    logic [31:0]           w_word;
    logic [15:0]           w_len;
    logic [7:0]            w_xor_next;

    // start is only honoured when no load is in flight
    assign w_start_ok = start && ((r_state == IDLE) || (r_state == DONE) ||
                                  (r_state == ERROR));
    assign w_len      = {r_len_hi, rx_data};
    assign w_xor_next = r_xor ^ rx_data;
    assign w_pk_valid = rx_valid && (r_state == DATA);

    byte_packer u_packer (
        .clk          (clk),
        .rst          (rst),
        .i_clear      (w_start_ok),
        .i_valid      (w_pk_valid),
        .i_byte       (rx_data),
        .o_word       (w_word),
        .o_word_valid (w_word_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_len_hi   <= 8'h00;
            r_xor      <= 8'h00;
            r_word_cnt <= '0;
            r_last     <= '0;
            we         <= 1'b0;
            wa         <= '0;
            wd         <= 32'h0;
            hold       <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            we <= 1'b0;
            if (w_start_ok) begin
                // A byte arriving together with an honoured start is dropped
                r_state    <= LEN_HI;
                r_xor      <= 8'h00;
                r_word_cnt <= '0;
                hold       <= 1'b1;
                done       <= 1'b0;
                err        <= 1'b0;
            end else if (rx_valid) begin
                case (r_state)
                    LEN_HI: begin
                        r_len_hi <= rx_data;
                        r_xor    <= w_xor_next;
                        r_state  <= LEN_LO;
                    end
                    LEN_LO: begin
                        r_xor <= w_xor_next;
                        if ({1'b0, w_len} > c_max_words) begin
                            r_state <= ERROR;
                            err     <= 1'b1;
                        end else if (w_len == 16'h0000) begin
                            r_state <= CSUM;
                        end else begin
                            // Index of the final word; N <= depth so it fits
                            r_last  <= DEPTH_LOG2'(w_len - 16'd1);
                            r_state <= DATA;
                        end
                    end
                    DATA: begin
                        r_xor <= w_xor_next;
                        if (w_word_valid) begin
                            we         <= 1'b1;
                            wa         <= r_word_cnt;
                            wd         <= w_word;
                            r_word_cnt <= r_word_cnt + DEPTH_LOG2'(1);
                            if (r_word_cnt == r_last) begin
                                r_state <= CSUM;
                            end
                        end
                    end
                    CSUM: begin
                        r_xor <= w_xor_next;
                        if (w_xor_next == 8'h00) begin
                            r_state <= DONE;
                            done    <= 1'b1;
                            hold    <= 1'b0;
                        end else begin
                            r_state <= ERROR;
                            err     <= 1'b1;
                        end
                    end
                    default: begin
                        // IDLE / DONE / ERROR: stray bytes are ignored
                    end
                endcase
            end
        end
    end

endmodule : inst_mem_loader
`default_nettype wire

// File: tb/tb_inst_mem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_mem_loader
// Description : Scoreboard testbench for inst_mem_loader. Frames are built
//               from word lists and the expected RAM writes and load outcome
//               are queued. A monitor pops and compares them as the DUT
//               presents them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_mem_loader;

    localparam int DL    = 6;
    localparam int DEPTH = 1 << DL;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          we;
    logic [DL-1:0] wa;
    logic [31:0]   wd;
    logic          hold;
    logic          done;
    logic          err;

    always #5 clk = ~clk;

    inst_mem_loader #(.DEPTH_LOG2(DL)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .we       (we),
        .wa       (wa),
        .wd       (wd),
        .hold     (hold),
        .done     (done),
        .err      (err)
    );

    typedef struct {
        logic [DL-1:0] wa;
        logic [31:0]   wd;
    } wr_t;

    wr_t         exp_wr[$];
    bit          exp_ok[$];
    logic [31:0] frame_words[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic        prev_fin = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        wr_t e;
        bit  ok;
        if (!rst) begin
            if (we) begin
                if (exp_wr.size() == 0) begin
                    chk("unexpected_we", {31'b0, we}, 32'd0);
                end else begin
                    e = exp_wr.pop_front();
                    chk("write_wa", {26'b0, wa}, {26'b0, e.wa});
                    chk("write_wd", wd, e.wd);
                end
            end
            if ((done || err) && !prev_fin) begin
                if (exp_ok.size() == 0) begin
                    chk("unexpected_finish", {30'b0, done, err}, 32'd0);
                end else begin
                    ok = exp_ok.pop_front();
                    chk("finish_done", {31'b0, done}, {31'b0, ok});
                    chk("finish_err",  {31'b0, err},  {31'b0, !ok});
                    chk("finish_hold", {31'b0, hold}, {31'b0, !ok});
                end
            end
        end
        prev_fin <= done || err;
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit with_start);
        rx_valid = 1'b1;
        rx_data  = b;
        start    = with_start;
        cyc();
        rx_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic do_start(input bit junk);
        start = 1'b1;
        if (junk) begin
            rx_valid = 1'b1;
            rx_data  = 8'($urandom);
        end
        cyc();
        start    = 1'b0;
        rx_valid = 1'b0;
        chk("start_hold", {31'b0, hold}, 32'd1);
        chk("start_done", {31'b0, done}, 32'd0);
        chk("start_err",  {31'b0, err},  32'd0);
    endtask

    task automatic fill_words(input int n, input bit index_mode);
        frame_words.delete();
        for (int i = 0; i < n; i++)
            frame_words.push_back(index_mode ? 32'(i) : $urandom);
    endtask

    task automatic wait_drain();
        int t = 0;
        while ((exp_wr.size() != 0 || exp_ok.size() != 0) && t < 40) begin
            cyc();
            t++;
        end
        chk("drain", 32'(exp_wr.size() + exp_ok.size()), 32'd0);
    endtask

    // Reference: frame = length, data MSB first, then csum such that the XOR
    // of every byte is zero. Over-long length -> error right after LEN_LO.
    task automatic run_frame(input int n_field, input bit flip, input bit b2b,
                             input int mid_start);
        logic [7:0]  bytes[$];
        logic [7:0]  x;
        logic [31:0] w;
        wr_t         e;
        bytes.push_back(n_field[15:8]);
        bytes.push_back(n_field[7:0]);
        if (n_field > DEPTH) begin
            exp_ok.push_back(1'b0);
        end else begin
            for (int i = 0; i < n_field; i++) begin
                w = frame_words[i];
                for (int b = 3; b >= 0; b--) bytes.push_back(w[8*b +: 8]);
                e.wa = DL'(i);
                e.wd = w;
                exp_wr.push_back(e);
            end
            x = 8'h00;
            foreach (bytes[k]) x ^= bytes[k];
            if (flip) x ^= 8'(1 << $urandom_range(0, 7));
            bytes.push_back(x);
            exp_ok.push_back(!flip);
        end
        foreach (bytes[k]) begin
            send_byte(bytes[k], k == mid_start);
            if (k == bytes.size() - 1)
                chk("finish_latency", {31'b0, done | err}, 32'd1);
            else if (!b2b)
                repeat ($urandom_range(0, 2)) cyc();
        end
        wait_drain();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int n;
        rst      = 1'b1;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) cyc();
        rst = 1'b0;
        chk("reset_we",   {31'b0, we},   32'd0);
        chk("reset_wa",   {26'b0, wa},   32'd0);
        chk("reset_wd",   wd,            32'd0);
        chk("reset_hold", {31'b0, hold}, 32'd1);
        chk("reset_done", {31'b0, done}, 32'd0);
        chk("reset_err",  {31'b0, err},  32'd0);
        repeat (10) cyc();
        chk("idle_hold", {31'b0, hold}, 32'd1);
        chk("idle_done", {31'b0, done}, 32'd0);
        chk("idle_err",  {31'b0, err},  32'd0);

        // Single known word
        do_start(1'b0);
        frame_words.delete();
        frame_words.push_back(32'h3C03C000);
        run_frame(1, 1'b0, 1'b0, -1);

        // Full RAM, back-to-back bytes, wd = index
        do_start(1'b0);
        fill_words(DEPTH, 1'b1);
        run_frame(DEPTH, 1'b0, 1'b1, -1);
        chk("full_last_wa", {26'b0, wa}, 32'(DEPTH - 1));

        // Length overflow, then recovery
        do_start(1'b0);
        frame_words.delete();
        run_frame(DEPTH + 1, 1'b0, 1'b0, -1);
        do_start(1'b0);
        fill_words(1, 1'b0);
        run_frame(1, 1'b0, 1'b0, -1);

        // Corrupted checksum after two writes
        do_start(1'b0);
        fill_words(2, 1'b0);
        run_frame(2, 1'b1, 1'b0, -1);

        // Reset mid-word: partial word must never be written
        do_start(1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h01, 1'b0);
        repeat (3) send_byte(8'($urandom), 1'b0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("midrst_hold", {31'b0, hold}, 32'd1);
        chk("midrst_done", {31'b0, done}, 32'd0);
        chk("midrst_err",  {31'b0, err},  32'd0);
        chk("midrst_wa",   {26'b0, wa},   32'd0);
        repeat (5) cyc();
        do_start(1'b0);
        fill_words(3, 1'b0);
        run_frame(3, 1'b0, 1'b0, -1);

        // Byte with the start is dropped; start during DATA is ignored
        do_start(1'b1);
        fill_words(2, 1'b0);
        run_frame(2, 1'b0, 1'b0, 4);

        // Randomised frames, including empty ones
        repeat (8) begin
            n = $urandom_range(0, 8);
            do_start(1'($urandom_range(0, 1)));
            fill_words(n, 1'b0);
            run_frame(n, $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)), -1);
        end

        repeat (5) cyc();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_inst_mem_loader
`default_nettype wire

// File: doc/inst_mem_loader.md
# inst_mem_loader

- Boot-time writer for the instruction RAM that replaces the fixed ROM. Takes a byte stream from the UART receiver, assembles big-endian 32-bit instructions and writes them word by word into instruction memory.
- Holds the CPU in reset until a complete, checksum-verified image is in memory.
- Sits between the serial receiver and the write port of the instruction RAM. The CPU fetch port of that RAM is untouched.

## Interface

- DEPTH_LOG2, 6, log2 of instruction RAM depth in words (64 words).
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle pulse; begins a new load.
- rx_data  in  8  received byte.
- rx_valid  in  1  one-cycle strobe; rx_data valid this cycle. No backpressure: every strobe is consumed or discarded.
- we  out  1  instruction RAM write enable, one cycle per word.
- wa  out  DEPTH_LOG2  word address of the write.
- wd  out  32  instruction word.
- hold  out  1  CPU reset request; high until a successful load.
- done  out  1  level; last load succeeded.
- err  out  1  level; last load failed (length overflow or bad checksum).

## Operation

Frame format:
- LEN_HI, LEN_LO: 16-bit word count N, big-endian.
- 4·N data bytes, MSB of each word first.
- CSUM byte, chosen so the XOR of every frame byte (length, data, CSUM) equals 0x00.

States and transitions:
- IDLE: start → LEN_HI.
- LEN_HI: on rx_valid → LEN_LO.
- LEN_LO: on rx_valid, if N > 2^DEPTH_LOG2 → ERROR. If N == 0 → CSUM. Otherwise → DATA.
- DATA: a byte counter (0..3) and a word counter (0..N-1) advance on each rx_valid. On the 4th byte of a word, pulse we. On the 4th byte of word N-1 → CSUM.
- CSUM: on rx_valid, if the running XOR including this byte is 0 → DONE, else → ERROR.
- DONE / ERROR: terminal; start → LEN_HI.

Rules and boundary cases:
- start is honoured only in IDLE, DONE and ERROR; it is ignored while a load is in progress.
- An rx_valid in the same cycle as an honoured start is discarded.
- rx_valid in IDLE, DONE or ERROR is discarded.
- Running XOR and both counters clear when LEN_HI is entered.
- On start, hold rises and done/err clear in the next cycle.
- Words already written before an ERROR remain in RAM. hold stays high.
- N == 2^DEPTH_LOG2 is legal: the last wa is all-ones and the address does not wrap.
- rst at any point → IDLE; in-progress word dropped, no we pulse.

## Timing

- Reset values: we=0, wa=0, wd=0, hold=1, done=0, err=0; state IDLE.
- All outputs are registered.
- Write latency: we=1 with valid wa/wd in the cycle after the rx_valid carrying the word's 4th byte. High exactly one cycle.
- wa/wd hold their values after we drops until the next write.
- Completion: the cycle after the CSUM byte's rx_valid, done=1 and hold=0 on success, or err=1 on failure.
- Length overflow: err=1 the cycle after the LEN_LO strobe.
- Back-to-back rx_valid on consecutive cycles is supported. Minimum gap between writes is 4 cycles.

## Structure

- Package inst_load_pkg:
  - state enum (IDLE, LEN_HI, LEN_LO, DATA, CSUM, DONE, ERROR)
  - default DEPTH_LOG2
  - HDR_BYTES=2
  - BYTES_PER_WORD=4
- Sub-module byte_packer: shift-in of 8-bit bytes MSB-first, 2-bit byte counter, word_valid pulse, synchronous clear. The FSM, word counter, XOR and outputs stay in inst_mem_loader.

## Test plan

- Reset, then idle 10 cycles → hold=1, done=0, err=0, we never asserted.
- start; bytes 00 01 3C 03 C0 00 CSUM=FE → one we with wa=0, wd=0x3C03C000. Next cycle after CSUM: done=1, hold=0.
- Load N=64 with wd=word index, bytes back-to-back every cycle → 64 we pulses, wa 0..63 in order, last wa=63, done=1.
- N=0x0041 (65) → err=1 the cycle after LEN_LO, no we. A second start plus a valid 1-word frame → done=1, err=0.
- Valid 2-word frame with CSUM bit-flipped → two we pulses, then err=1, hold=1, done=0.
- Assert rst after the 3rd data byte → no we. start plus a full frame → wa starts at 0 and the load succeeds.
- Extra start pulse mid-DATA, plus an rx_valid in the same cycle as the initial start → the mid-DATA start is ignored, the same-cycle byte is discarded, and the expected frame completes with done=1.
